// File: rtl/irq_pkg.sv
// Shared constants and state encoding for the 32-source interrupt encoder.
package irq_pkg;

  localparam int NUM_SRC = 32;
  localparam int IDX_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] IRQ_ID_RST = '0;

endpackage

// File: rtl/prio_enc32.sv
// Combinational 32-to-5 priority encoder, bit 0 highest priority.
module prio_enc32
  import irq_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_vec,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any,
  output logic               o_multi
);

  logic [NUM_SRC-1:0] w_minus1;

  assign w_minus1 = i_vec - {{(NUM_SRC-1){1'b0}}, 1'b1};
  assign o_any    = |i_vec;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign o_multi  = |(i_vec & w_minus1);

  always_comb begin
    o_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_encoder32.sv
// Interrupt encoder: edge capture into sticky pending, mask, and valid/ack presentation.
// state | meaning
// IDLE  | no request presented; waiting for en and a masked pending bit
// REQ   | irq_id frozen and presented until ack
// GAP   | one cycle of irq_valid=0 between back-to-back requests
module irq_encoder32
  import irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               ack,
  input  logic               clr_all,
  output logic               irq_valid,
  output logic [IDX_W-1:0]   irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               irq_multi
);

  logic [NUM_SRC-1:0] r_prev_irq;
  logic [NUM_SRC-1:0] r_pending;
  logic               r_valid;
  logic [IDX_W-1:0]   r_id;
  logic               r_multi;
  state_t             r_state;

  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_mp;
  logic [NUM_SRC-1:0] w_pending_nxt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_multi;
  logic               w_ack_acc;
  state_t             w_state_nxt;
  logic               w_valid_nxt;
  logic [IDX_W-1:0]   w_id_nxt;

  assign w_rise    = irq_in & ~r_prev_irq;
  assign w_mp      = r_pending & mask;
  assign w_ack_acc = (r_state == REQ) && ack;

  always_comb begin
    w_clr = '0;
    if (w_ack_acc) w_clr[r_id] = 1'b1;
    if (clr_all)   w_clr = '1;
  end

  // OR-ing the rise after the clear keeps an event that lands on the clearing edge.
  assign w_pending_nxt = (r_pending & ~w_clr) | w_rise;

  prio_enc32 u_prio (
    .i_vec   (w_mp),
    .o_idx   (w_idx),
    .o_any   (w_any),
    .o_multi (w_multi)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_id_nxt    = r_id;
    case (r_state)
      IDLE: begin
        w_valid_nxt = 1'b0;
        if (en && w_any) begin
          w_state_nxt = REQ;
          w_valid_nxt = 1'b1;
          w_id_nxt    = w_idx;
        end
      end
      REQ: begin
        w_valid_nxt = 1'b1;
        if (ack) begin
          w_state_nxt = GAP;
          w_valid_nxt = 1'b0;
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_valid    <= 1'b0;
      r_id       <= IRQ_ID_RST;
      r_prev_irq <= '0;
      r_pending  <= '0;
      r_multi    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_valid    <= w_valid_nxt;
      r_id       <= w_id_nxt;
      r_prev_irq <= irq_in;
      r_pending  <= w_pending_nxt;
      r_multi    <= w_multi;
    end
  end

  assign irq_valid = r_valid;
  assign irq_id    = r_id;
  assign pending   = r_pending;
  assign irq_multi = r_multi;

endmodule

// File: tb/tb_irq_encoder32.sv
// Scoreboard bench: stimulus queues expected presentations, a negedge monitor checks them.
module tb_irq_encoder32;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] irq_in;
  logic [31:0] mask;
  logic        ack;
  logic        clr_all;
  logic        irq_valid;
  logic [4:0]  irq_id;
  logic [31:0] pending;
  logic        irq_multi;

  typedef struct packed {
    logic [4:0] id;
    logic       multi;
  } exp_t;

  exp_t q_exp[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_prev_valid = 1'b0;

  irq_encoder32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .irq_in    (irq_in),
    .mask      (mask),
    .ack       (ack),
    .clr_all   (clr_all),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending),
    .irq_multi (irq_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] id, input logic multi);
    exp_t e;
    e.id    = id;
    e.multi = multi;
    q_exp.push_back(e);
  endtask

  // Ack the current request, then let GAP and IDLE pass.
  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("valid_after_ack", {31'd0, irq_valid}, 32'd0);
    tick();
    chk("valid_in_gap", {31'd0, irq_valid}, 32'd0);
    tick();
  endtask

  // Monitor: every new presentation (rising irq_valid) must match the queue head.
  always @(negedge clk) begin
    if (irq_valid && !mon_prev_valid) begin
      if (q_exp.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_present: got id %0d with nothing expected at %0t", irq_id, $time);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        chk("present_id", {27'd0, irq_id}, {27'd0, e.id});
        chk("present_multi", {31'd0, irq_multi}, {31'd0, e.multi});
      end
    end
    mon_prev_valid <= irq_valid;
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    irq_in  = '0;
    mask    = '1;
    ack     = 1'b0;
    clr_all = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, irq_valid}, 32'd0);
    chk("rst_id", {27'd0, irq_id}, 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_multi", {31'd0, irq_multi}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single source 9
    irq_in[9] = 1'b1;
    tick();
    irq_in = '0;
    chk("single_pending", pending, 32'h0000_0200);
    chk("single_valid_k", {31'd0, irq_valid}, 32'd0);
    push(5'd9, 1'b0);
    tick();
    chk("single_valid", {31'd0, irq_valid}, 32'd1);
    chk("single_id", {27'd0, irq_id}, 32'd9);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("single_pending_clr", pending, 32'd0);
    chk("single_valid_clr", {31'd0, irq_valid}, 32'd0);
    tick();
    chk("single_gap", {31'd0, irq_valid}, 32'd0);
    tick();
    chk("single_idle", {31'd0, irq_valid}, 32'd0);

    // Priority 3 vs 20, then queued 20 two cycles after ack
    irq_in = 32'h0010_0008;
    push(5'd3, 1'b1);
    tick();
    irq_in = '0;
    tick();
    chk("prio_id", {27'd0, irq_id}, 32'd3);
    chk("prio_multi", {31'd0, irq_multi}, 32'd1);
    push(5'd20, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("prio_pending", pending, 32'h0010_0000);
    chk("prio_valid_a", {31'd0, irq_valid}, 32'd0);
    tick();
    chk("prio_valid_a1", {31'd0, irq_valid}, 32'd0);
    tick();
    chk("prio_valid_a2", {31'd0, irq_valid}, 32'd1);
    chk("prio_id_a2", {27'd0, irq_id}, 32'd20);
    chk("prio_multi_a2", {31'd0, irq_multi}, 32'd0);
    do_ack();

    // Mask holds off source 5
    mask = ~32'h0000_0020;
    irq_in[5] = 1'b1;
    tick();
    irq_in = '0;
    chk("mask_pending", pending, 32'h0000_0020);
    tick();
    tick();
    chk("mask_novalid", {31'd0, irq_valid}, 32'd0);
    mask = '1;
    push(5'd5, 1'b0);
    tick();
    chk("mask_valid", {31'd0, irq_valid}, 32'd1);
    chk("mask_id", {27'd0, irq_id}, 32'd5);
    do_ack();

    // en=0 holds off presentation but pending still accumulates
    en = 1'b0;
    irq_in[5] = 1'b1;
    tick();
    irq_in = '0;
    tick();
    tick();
    chk("en_novalid", {31'd0, irq_valid}, 32'd0);
    chk("en_pending", pending, 32'h0000_0020);
    en = 1'b1;
    push(5'd5, 1'b0);
    tick();
    chk("en_valid", {31'd0, irq_valid}, 32'd1);
    do_ack();

    // Re-rise on the ack edge survives the clear
    irq_in[12] = 1'b1;
    push(5'd12, 1'b0);
    tick();
    irq_in = '0;
    tick();
    chk("coll_id", {27'd0, irq_id}, 32'd12);
    irq_in[12] = 1'b1;
    ack = 1'b1;
    push(5'd12, 1'b0);
    tick();
    irq_in = '0;
    ack = 1'b0;
    chk("coll_pending", pending, 32'h0000_1000);
    tick();
    tick();
    chk("coll_valid_again", {31'd0, irq_valid}, 32'd1);
    chk("coll_id_again", {27'd0, irq_id}, 32'd12);
    do_ack();
    chk("coll_pending_end", pending, 32'd0);

    // Frozen request: masking 4 and raising 1 does not disturb it
    irq_in[4] = 1'b1;
    push(5'd4, 1'b0);
    tick();
    irq_in = '0;
    tick();
    mask[4] = 1'b0;
    irq_in[1] = 1'b1;
    tick();
    irq_in = '0;
    tick();
    chk("frozen_valid", {31'd0, irq_valid}, 32'd1);
    chk("frozen_id", {27'd0, irq_id}, 32'd4);
    push(5'd1, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    mask = '1;
    tick();
    tick();
    chk("frozen_next_id", {27'd0, irq_id}, 32'd1);
    do_ack();

    // clr_all during REQ clears pending but keeps the request up
    irq_in[7] = 1'b1;
    push(5'd7, 1'b0);
    tick();
    irq_in = '0;
    tick();
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    chk("clr_pending", pending, 32'd0);
    chk("clr_valid", {31'd0, irq_valid}, 32'd1);
    tick();
    chk("clr_id", {27'd0, irq_id}, 32'd7);
    do_ack();
    chk("clr_pending_end", pending, 32'd0);

    // Held-high line sets pending only once
    irq_in[10] = 1'b1;
    push(5'd10, 1'b0);
    tick();
    tick();
    chk("held_id", {27'd0, irq_id}, 32'd10);
    do_ack();
    tick();
    chk("held_novalid", {31'd0, irq_valid}, 32'd0);
    chk("held_pending", pending, 32'd0);
    irq_in = '0;
    tick();

    // ack outside REQ is ignored
    mask = ~32'h0000_0020;
    irq_in[5] = 1'b1;
    tick();
    irq_in = '0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("stray_ack_pending", pending, 32'h0000_0020);
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    mask = '1;
    chk("stray_clr", pending, 32'd0);
    tick();

    // Async reset mid-REQ with id 7 and another event pending
    irq_in[7] = 1'b1;
    push(5'd7, 1'b0);
    tick();
    irq_in = '0;
    tick();
    irq_in[2] = 1'b1;
    tick();
    irq_in = '0;
    chk("prerst_id", {27'd0, irq_id}, 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, irq_valid}, 32'd0);
    chk("arst_id", {27'd0, irq_id}, 32'd0);
    chk("arst_pending", pending, 32'd0);
    chk("arst_multi", {31'd0, irq_multi}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", {31'd0, irq_valid}, 32'd0);
    chk("post_rst_id", {27'd0, irq_id}, 32'd0);
    chk("post_rst_pending", pending, 32'd0);
    tick();

    chk("queue_drained", q_exp.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
